// File: rtl/qspi_cmd_arbiter_if.sv
// Signal bundle between the command requesters, the command arbiter and the
// qspi_controller config/start/done ports.
`ifndef REG_WIDTH_DEFAULT
`define REG_WIDTH_DEFAULT 32
`endif

interface qspi_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CFG_BITS = `REG_WIDTH_DEFAULT
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*CFG_BITS-1:0] req_cfg0;
  logic [NUM_REQ*CFG_BITS-1:0] req_cfg1;
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_REQ-1:0]          ack;
  logic                        err;
  logic                        q_busy;
  logic                        q_done;
  logic                        config_addr;
  logic                        config_write;
  logic [CFG_BITS-1:0]         config_data;
  logic                        start;

  // Arbiter side
  modport slave (
    input  req, req_cfg0, req_cfg1, q_busy, q_done,
    output grant, ack, err, config_addr, config_write, config_data, start
  );

  // Requesters and controller side
  modport master (
    output req, req_cfg0, req_cfg1, q_busy, q_done,
    input  grant, ack, err, config_addr, config_write, config_data, start
  );
endinterface

// File: rtl/qspi_cmd_arbiter.sv
// Round-robin arbiter sharing one qspi_controller between NUM_REQ command requesters:
// programs the owner's two config words, pulses start, waits for done or timeout, then acks.
`ifndef REG_WIDTH_DEFAULT
`define REG_WIDTH_DEFAULT 32
`endif

module qspi_cmd_arbiter #(
  parameter int unsigned              NUM_REQ        = 4,
  parameter int unsigned              CFG_BITS       = `REG_WIDTH_DEFAULT,
  parameter int unsigned              TIMEOUT_BITS   = 16,
  parameter logic [TIMEOUT_BITS-1:0]  TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  qspi_cmd_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST = TIMEOUT_CYCLES - TIMEOUT_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG0, S_CFG1, S_START, S_WAIT_DONE, S_FINISH
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    cfg_wr_q, cfg_wr_d;
  logic                    cfg_addr_q, cfg_addr_d;
  logic [CFG_BITS-1:0]     cfg_data_q, cfg_data_d;
  logic                    start_q, start_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [CFG_BITS-1:0]     cfg0_q, cfg0_d;
  logic [CFG_BITS-1:0]     cfg1_q, cfg1_d;
  logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;

  logic                    pick_vld_c;
  logic [IDX_W-1:0]        pick_idx_c;
  logic [IDX_W-1:0]        scan_idx_c;
  logic [CFG_BITS-1:0]     pick_cfg0_c;
  logic [CFG_BITS-1:0]     pick_cfg1_c;
  logic                    unused_busy;

  // Controller busy is status only and never steers sequencing
  assign unused_busy = bus.q_busy;

  // Round-robin pick: descending scan so the smallest offset from rr_q wins
  always_comb begin
    pick_vld_c  = 1'b0;
    pick_idx_c  = rr_q;
    scan_idx_c  = rr_q;
    pick_cfg0_c = '0;
    pick_cfg1_c = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      scan_idx_c = IDX_W'((32'(rr_q) + 32'(k)) % NUM_REQ);
      if (bus.req[scan_idx_c]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = scan_idx_c;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_c == IDX_W'(i)) begin
        pick_cfg0_c = bus.req_cfg0[i*CFG_BITS +: CFG_BITS];
        pick_cfg1_c = bus.req_cfg1[i*CFG_BITS +: CFG_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (pick_vld_c) state_d = S_CFG0;
      S_CFG0:      state_d = S_CFG1;
      S_CFG1:      state_d = S_START;
      S_START:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.q_done || (wdog_q == WDOG_LAST)) state_d = S_FINISH;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so each is set on the transition into the state that shows it
  always_comb begin
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cfg0_d     = cfg0_q;
    cfg1_d     = cfg1_q;
    wdog_d     = wdog_q;
    ack_d      = '0;
    err_d      = 1'b0;
    cfg_wr_d   = 1'b0;
    cfg_addr_d = 1'b0;
    cfg_data_d = '0;
    start_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld_c) begin
          grant_d    = NUM_REQ'(1) << pick_idx_c;
          owner_d    = pick_idx_c;
          cfg0_d     = pick_cfg0_c;
          cfg1_d     = pick_cfg1_c;
          cfg_wr_d   = 1'b1;
          cfg_data_d = pick_cfg0_c;
        end
      end
      S_CFG0: begin
        cfg_wr_d   = 1'b1;
        cfg_addr_d = 1'b1;
        cfg_data_d = cfg1_q;
      end
      S_CFG1:  start_d = 1'b1;
      S_START: wdog_d  = '0;
      S_WAIT_DONE: begin
        wdog_d = wdog_q + TIMEOUT_BITS'(1);
        if (bus.q_done) begin
          ack_d = grant_q;
        end else if (wdog_q == WDOG_LAST) begin
          ack_d = grant_q;
          err_d = 1'b1;
        end
      end
      S_FINISH: begin
        grant_d = '0;
        rr_d    = IDX_W'((32'(owner_q) + 32'd1) % NUM_REQ);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      cfg_wr_q   <= 1'b0;
      cfg_addr_q <= 1'b0;
      cfg_data_q <= '0;
      start_q    <= 1'b0;
      owner_q    <= '0;
      rr_q       <= '0;
      cfg0_q     <= '0;
      cfg1_q     <= '0;
      wdog_q     <= '0;
    end else begin
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      cfg_wr_q   <= cfg_wr_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      start_q    <= start_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cfg0_q     <= cfg0_d;
      cfg1_q     <= cfg1_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.ack          = ack_q;
  assign bus.err          = err_q;
  assign bus.config_write = cfg_wr_q;
  assign bus.config_addr  = cfg_addr_q;
  assign bus.config_data  = cfg_data_q;
  assign bus.start        = start_q;

endmodule

// File: tb/tb_qspi_cmd_arbiter.sv
// Self-checking bench for qspi_cmd_arbiter: directed cases plus randomized transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_qspi_cmd_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CB = 16;
  localparam int          TO = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qspi_cmd_arbiter_if #(.NUM_REQ(N), .CFG_BITS(CB)) bus_if();

  qspi_cmd_arbiter #(
    .NUM_REQ(N), .CFG_BITS(CB), .TIMEOUT_BITS(16), .TIMEOUT_CYCLES(16'(TO))
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int rr_m     = 0;
  logic [CB-1:0] cfg0_m [N];
  logic [CB-1:0] cfg1_m [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg();
    bus_if.req_cfg0 = {cfg0_m[3], cfg0_m[2], cfg0_m[1], cfg0_m[0]};
    bus_if.req_cfg1 = {cfg1_m[3], cfg1_m[2], cfg1_m[1], cfg1_m[0]};
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < int'(N); i++) begin
      cfg0_m[i] = CB'($urandom);
      cfg1_m[i] = CB'($urandom);
    end
    drive_cfg();
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    logic [N-1:0] rv;
    rv = r;
    for (int k = 0; k < int'(N); k++)
      if (rv[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
    return 0;
  endfunction

  // One full transaction starting from an IDLE cycle. done_at = index of the WAIT_DONE
  // cycle in which q_done is driven (negative = never); poke changes cfg inputs after
  // grant and pulses q_done outside WAIT_DONE.
  task automatic txn(input logic [N-1:0] reqm, input int done_at, input bit drop,
                     input bit poke, input bit keep_cfg);
    int w;
    int k;
    bit e_err;
    logic [CB-1:0] e0, e1;
    if (!keep_cfg) rand_cfg();
    else drive_cfg();
    bus_if.req = reqm;
    w  = pick(reqm, rr_m);
    e0 = cfg0_m[w];
    e1 = cfg1_m[w];

    tick();
    chk("cfg0_grant", 64'(bus_if.grant), 64'(1) << w);
    chk("cfg0_write", 64'(bus_if.config_write), 64'd1);
    chk("cfg0_addr",  64'(bus_if.config_addr), 64'd0);
    chk("cfg0_data",  64'(bus_if.config_data), 64'(e0));
    chk("cfg0_start", 64'(bus_if.start), 64'd0);
    chk("cfg0_ack",   64'(bus_if.ack), 64'd0);
    if (poke) begin rand_cfg(); bus_if.q_done = 1'b1; end

    tick();
    bus_if.q_done = 1'b0;
    chk("cfg1_grant", 64'(bus_if.grant), 64'(1) << w);
    chk("cfg1_write", 64'(bus_if.config_write), 64'd1);
    chk("cfg1_addr",  64'(bus_if.config_addr), 64'd1);
    chk("cfg1_data",  64'(bus_if.config_data), 64'(e1));
    chk("cfg1_start", 64'(bus_if.start), 64'd0);
    if (poke) rand_cfg();

    tick();
    chk("start_pulse", 64'(bus_if.start), 64'd1);
    chk("start_write", 64'(bus_if.config_write), 64'd0);
    chk("start_grant", 64'(bus_if.grant), 64'(1) << w);
    if (poke) bus_if.q_done = 1'b1;

    tick();
    k = 0;
    e_err = 1'b0;
    while (1) begin
      chk("wait_start", 64'(bus_if.start), 64'd0);
      chk("wait_write", 64'(bus_if.config_write), 64'd0);
      chk("wait_ack",   64'(bus_if.ack), 64'd0);
      chk("wait_grant", 64'(bus_if.grant), 64'(1) << w);
      bus_if.q_busy = 1'($urandom);
      if (drop && k == 1) bus_if.req = '0;
      bus_if.q_done = (k == done_at);
      if (k == done_at) begin e_err = 1'b0; break; end
      if (k == TO - 1)  begin e_err = 1'b1; break; end
      tick();
      k++;
    end

    tick();
    bus_if.q_done = 1'b0;
    chk("fin_ack",   64'(bus_if.ack), 64'(1) << w);
    chk("fin_err",   64'(bus_if.err), 64'(e_err));
    chk("fin_grant", 64'(bus_if.grant), 64'(1) << w);
    chk("fin_start", 64'(bus_if.start), 64'd0);
    rr_m = (w + 1) % int'(N);

    tick();
    bus_if.req = '0;
    chk("idle_grant", 64'(bus_if.grant), 64'd0);
    chk("idle_ack",   64'(bus_if.ack), 64'd0);
    chk("idle_err",   64'(bus_if.err), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(bus_if.grant), 64'd0);
    chk({tag, "_ack"},   64'(bus_if.ack), 64'd0);
    chk({tag, "_err"},   64'(bus_if.err), 64'd0);
    chk({tag, "_write"}, 64'(bus_if.config_write), 64'd0);
    chk({tag, "_addr"},  64'(bus_if.config_addr), 64'd0);
    chk({tag, "_data"},  64'(bus_if.config_data), 64'd0);
    chk({tag, "_start"}, 64'(bus_if.start), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r;
    int dat;
    reset = 1'b1;
    bus_if.req = '0;
    bus_if.q_done = 1'b0;
    bus_if.q_busy = 1'b0;
    rand_cfg();
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("post_reset_idle");

    // Single requester with fixed words, done in the 20th WAIT_DONE cycle
    cfg0_m[2] = 16'h00A5;
    cfg1_m[2] = 16'h003C;
    txn(4'b0100, 19, 1'b0, 1'b0, 1'b1);

    // All requesting: rotation 3,0,1,2,3 continues from the pointer left at 3
    for (int i = 0; i < 5; i++) txn(4'b1111, 4, 1'b0, 1'b0, 1'b0);

    // Timeout, then a normal request served
    txn(4'b0010, -1, 1'b0, 1'b0, 1'b0);
    txn(4'b0010, 2, 1'b0, 1'b0, 1'b0);

    // q_done on the timeout cycle wins; request dropped mid-wait still acked
    txn(4'b1000, TO - 1, 1'b0, 1'b0, 1'b0);
    txn(4'b0100, 6, 1'b1, 1'b0, 1'b0);

    // Config changes and stray q_done after grant
    txn(4'b0001, 3, 1'b0, 1'b1, 1'b0);

    // Reset during CFG1 aborts with no ack and clears the pointer
    rand_cfg();
    bus_if.req = 4'b0100;
    tick();
    tick();
    chk("pre_reset_cfg1", 64'(bus_if.config_addr), 64'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("reset_cfg1");
    reset = 1'b0;
    rr_m = 0;
    txn(4'b1001, 1, 1'b0, 1'b0, 1'b0);
    chk("rr_after_reset_next", 64'(rr_m), 64'd1);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      dat = -1;
      else if (r == 1) dat = TO - 1;
      else             dat = int'($urandom_range(0, TO - 2));
      txn(N'($urandom_range(1, 15)), dat, ($urandom_range(0, 3) == 0),
          1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
